uart_rx_cmd_ctrl: RTL

Command-frame controller behind uart_rx. It consumes the received byte stream (o_data/o_vld of uart_rx) and sequences a 5-byte register-write protocol: SYNC, ADDR, DATA_LO, DATA_HI, CSUM. Validated commands are presented on a valid/ready port to the register file. Checksum errors, inter-byte timeouts and output overruns are flagged with single-cycle pulses.

---
 rtl/uart_rx_cmd_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// Frame parser for the 5-byte UART register-write protocol: SYNC, ADDR, DATA_LO, DATA_HI, CSUM.
// Validated commands are held on a valid/ready port; errors are reported as one-cycle pulses.
module uart_rx_cmd_ctrl #(
    parameter int          FREQ         = 50_000_000,
    parameter int          RATE         = 2_000_000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_vld,
    output logic [7:0]  o_cmd_addr,
    output logic [15:0] o_cmd_data,
    output logic        o_cmd_vld,
    input  logic        i_cmd_rdy,
    output logic        o_busy,
    output logic        o_csum_err,
    output logic        o_tout_err,
    output logic        o_ovf
);

    localparam int BIT_CYC  = FREQ / RATE;
    localparam int TOUT_CYC = BIT_CYC * TIMEOUT_BITS;
    localparam int CW       = $clog2(TOUT_CYC + 1);
    localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DLO  = 3'd2,
        DHI  = 3'd3,
        CSUM = 3'd4
    } state_t;

    state_t        state;
    logic [7:0]    addr_sh;
    logic [7:0]    dlo_sh;
    logic [7:0]    dhi_sh;
    logic [CW-1:0] tout_cnt;
    logic          csum_ok;
    logic          out_free;

    // Command port: o_cmd_addr/o_cmd_data hold steady while o_cmd_vld is high; the
    // command transfers on a posedge with o_cmd_vld && i_cmd_rdy, and a new command
    // may load in that same cycle so o_cmd_vld stays high back-to-back.
    assign csum_ok  = (i_data == (addr_sh ^ dlo_sh ^ dhi_sh));
    assign out_free = !o_cmd_vld || i_cmd_rdy;
    assign o_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_sh    <= 8'h00;
            dlo_sh     <= 8'h00;
            dhi_sh     <= 8'h00;
            tout_cnt   <= '0;
            o_cmd_addr <= 8'h00;
            o_cmd_data <= 16'h0000;
            o_cmd_vld  <= 1'b0;
            o_csum_err <= 1'b0;
            o_tout_err <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            o_csum_err <= 1'b0;
            o_tout_err <= 1'b0;
            o_ovf      <= 1'b0;
            if (o_cmd_vld && i_cmd_rdy) begin
                o_cmd_vld <= 1'b0;
            end

            if (state == IDLE) begin
                tout_cnt <= '0;
                if (i_vld && (i_data == SYNC_BYTE)) begin
                    state <= ADDR;
                end
            end else if (i_vld) begin
                // A byte on the limit cycle still counts, so i_vld is tested before the timeout.
                tout_cnt <= '0;
                case (state)
                    ADDR: begin
                        addr_sh <= i_data;
                        state   <= DLO;
                    end
                    DLO: begin
                        dlo_sh <= i_data;
                        state  <= DHI;
                    end
                    DHI: begin
                        dhi_sh <= i_data;
                        state  <= CSUM;
                    end
                    CSUM: begin
                        state <= IDLE;
                        if (!csum_ok) begin
                            o_csum_err <= 1'b1;
                        end else if (out_free) begin
                            o_cmd_addr <= addr_sh;
                            o_cmd_data <= {dhi_sh, dlo_sh};
                            o_cmd_vld  <= 1'b1;
                        end else begin
                            o_ovf <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (tout_cnt == TOUT_LAST) begin
                state      <= IDLE;
                tout_cnt   <= '0;
                o_tout_err <= 1'b1;
            end else begin
                tout_cnt <= tout_cnt + 1'b1;
            end
        end
    end

endmodule
